// File: rtl/alt_vipcto130_common_sample_sequencer_pkg.sv
// Shared definitions for the clocked-video sample counter / sequencer pair.
//
// Contents:
//   out_mode_e      - how the colour planes of a sample leave the block
//   plane_idx_width - width of a plane index counter (clog2, at least 1 bit)
//   plane_lsb       - bit position of a colour plane inside a packed sample
package alt_vipcto130_common_sample_sequencer_pkg;

    // hd_sdn=1 emits the whole sample per word; hd_sdn=0 emits one plane per word.
    typedef enum logic {
        MODE_SEQUENTIAL = 1'b0,
        MODE_PARALLEL   = 1'b1
    } out_mode_e;

    // A single-plane design still keeps a one-bit index so ports never collapse to zero width.
    function automatic int plane_idx_width(input int planes);
        return (planes <= 2) ? 1 : $clog2(planes);
    endfunction

    // Plane 0 lives in the least significant bits of the sample.
    function automatic int plane_lsb(input int plane, input int bps);
        return plane * bps;
    endfunction

endpackage

// File: rtl/alt_vipcto130_common_plane_counter.sv
// Plane index counter for the output-side sample sequencer.
//
// Steps through the colour planes of the sample currently held, one plane per
// consumed word, and wraps to plane 0 on the last plane. In parallel mode every
// word is the last plane, so the index stays at 0.
//
// Ports:
//   clk, rst_n       - video clock, asynchronous active-low reset
//   sclr             - synchronous clear of the index
//   hd_sdn           - 1 = parallel planes, 0 = sequential planes
//   consume          - one output word is taken this cycle
//   plane_idx        - index of the plane currently presented
//   last_plane       - current word completes the sample
//   start_of_sample  - current word is plane 0 of a sample
module alt_vipcto130_common_plane_counter
    import alt_vipcto130_common_sample_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_COLOUR_PLANES = 3,
    parameter int IDX_W                   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             hd_sdn,
    input  logic             consume,
    output logic [IDX_W-1:0] plane_idx,
    output logic             last_plane,
    output logic             start_of_sample
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_COLOUR_PLANES - 1);

    logic [IDX_W-1:0] idxQ;
    logic [IDX_W-1:0] idxD;

    // The index only advances while it is below the last plane, so codes above
    // NUMBER_OF_COLOUR_PLANES-1 are never reached. A mid-sample switch to
    // parallel mode makes the next word "last" and returns the index to 0.
    always_comb begin
        last_plane      = hd_sdn | (idxQ == LAST_IDX);
        start_of_sample = hd_sdn | (idxQ == '0);
        idxD            = idxQ;
        if (sclr) begin
            idxD = '0;
        end else if (consume) begin
            idxD = last_plane ? '0 : idxQ + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idxQ <= '0;
        end else begin
            idxQ <= idxD;
        end
    end

    assign plane_idx = idxQ;

endmodule

// File: rtl/alt_vipcto130_common_sample_sequencer.sv
// Output-side sample sequencer for clocked video output.
//
// Takes whole samples (all colour planes in parallel) over a valid/ready
// handshake into a single hold register and presents them to the CVO timing
// logic either one plane per enabled cycle (SD) or one sample per enabled
// cycle (HD).
//
// Ports:
//   clk, rst_n        - video clock, asynchronous active-low reset
//   sclr              - synchronous clear, overrides all other activity
//   hd_sdn            - 1 = parallel planes, 0 = sequential planes
//   in_valid/in_ready - upstream sample handshake
//   in_data           - incoming sample, plane 0 in the LSBs
//   out_enable        - downstream takes one word this cycle
//   out_valid         - hold register contains a sample
//   out_data          - current output word
//   start_of_sample   - current word is plane 0
//   sample_ticks      - index of the current plane
//   underflow         - sticky flag: word requested while empty
module alt_vipcto130_common_sample_sequencer
    import alt_vipcto130_common_sample_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
    parameter int BPS                          = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    sclr,
    input  logic                                    hd_sdn,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0]  in_data,
    input  logic                                    out_enable,
    output logic                                    out_valid,
    output logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0]  out_data,
    output logic                                    start_of_sample,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
    output logic                                    underflow
);

    localparam int DW    = BPS * NUMBER_OF_COLOUR_PLANES;
    localparam int IDX_W = LOG2_NUMBER_OF_COLOUR_PLANES;

    logic [DW-1:0]    holdQ, holdD;
    logic             holdValidQ, holdValidD;
    logic             underflowQ, underflowD;
    logic [IDX_W-1:0] planeIdx;
    logic             lastPlane;
    logic             consume;
    logic             accept;
    logic [BPS-1:0]   planeWord;
    out_mode_e        mode;

    assign mode    = out_mode_e'(hd_sdn);
    assign consume = out_enable & holdValidQ;

    alt_vipcto130_common_plane_counter #(
        .NUMBER_OF_COLOUR_PLANES (NUMBER_OF_COLOUR_PLANES),
        .IDX_W                   (IDX_W)
    ) u_plane_counter (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclr            (sclr),
        .hd_sdn          (hd_sdn),
        .consume         (consume),
        .plane_idx       (planeIdx),
        .last_plane      (lastPlane),
        .start_of_sample (start_of_sample)
    );

    // Ready is combinational on the last-plane consume so a new sample can be
    // loaded in the same cycle the old one finishes, giving no bubble.
    always_comb begin
        in_ready = !sclr & (!holdValidQ | (consume & lastPlane));
        accept   = in_valid & in_ready;

        holdD      = accept ? in_data : holdQ;
        holdValidD = accept | (holdValidQ & !(consume & lastPlane));
        underflowD = underflowQ | (out_enable & !holdValidQ);

        if (sclr) begin
            holdValidD = 1'b0;
            underflowD = 1'b0;
        end
    end

    // The hold register keeps its stale contents when emptied; out_data is
    // meaningless while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdQ      <= '0;
            holdValidQ <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            holdQ      <= holdD;
            holdValidQ <= holdValidD;
            underflowQ <= underflowD;
        end
    end

    // Constant-slice mux keeps every select in range even when the plane
    // count is not a power of two.
    always_comb begin
        planeWord = '0;
        for (int p = 0; p < NUMBER_OF_COLOUR_PLANES; p++) begin
            if (planeIdx == IDX_W'(p)) begin
                planeWord = holdQ[plane_lsb(p, BPS) +: BPS];
            end
        end
    end

    assign out_data     = (mode == MODE_PARALLEL) ? holdQ : DW'(planeWord);
    assign out_valid    = holdValidQ;
    assign sample_ticks = planeIdx;
    assign underflow    = underflowQ;

endmodule

// File: tb/tb_alt_vipcto130_common_sample_sequencer.sv
// Directed self-checking bench for alt_vipcto130_common_sample_sequencer.
// dut is the 3-plane, 8-bit configuration; dut1 is a single-plane instance
// sharing clock, reset, sclr and mode.
module tb_alt_vipcto130_common_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclr = 1'b0;
    logic        hd_sdn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        out_enable = 1'b0;
    logic        out_valid;
    logic [23:0] out_data;
    logic        start_of_sample;
    logic [1:0]  sample_ticks;
    logic        underflow;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [7:0]  in_data1 = '0;
    logic        out_enable1 = 1'b0;
    logic        out_valid1;
    logic [7:0]  out_data1;
    logic        start_of_sample1;
    logic [0:0]  sample_ticks1;
    logic        underflow1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alt_vipcto130_common_sample_sequencer #(
        .NUMBER_OF_COLOUR_PLANES      (3),
        .LOG2_NUMBER_OF_COLOUR_PLANES (2),
        .BPS                          (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclr            (sclr),
        .hd_sdn          (hd_sdn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_enable      (out_enable),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .start_of_sample (start_of_sample),
        .sample_ticks    (sample_ticks),
        .underflow       (underflow)
    );

    alt_vipcto130_common_sample_sequencer #(
        .NUMBER_OF_COLOUR_PLANES      (1),
        .LOG2_NUMBER_OF_COLOUR_PLANES (1),
        .BPS                          (8)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclr            (sclr),
        .hd_sdn          (hd_sdn),
        .in_valid        (in_valid1),
        .in_ready        (in_ready1),
        .in_data         (in_data1),
        .out_enable      (out_enable1),
        .out_valid       (out_valid1),
        .out_data        (out_data1),
        .start_of_sample (start_of_sample1),
        .sample_ticks    (sample_ticks1),
        .underflow       (underflow1)
    );

    // Drives the 3-plane instance's handshake inputs and lets them settle.
    task automatic applyStimulus(input logic v, input logic [23:0] d, input logic en);
        in_valid   = v;
        in_data    = d;
        out_enable = en;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advances past the next rising edge; inputs change and checks happen mid-cycle.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        checkOutput("rst_sos", 32'(start_of_sample), 32'h1);
        checkOutput("rst_ticks", 32'(sample_ticks), 32'h0);
        checkOutput("rst_underflow", 32'(underflow), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // 1: one sample emitted as three planes
        applyStimulus(1'b1, 24'h332211, 1'b0);
        checkOutput("t1_ready_empty", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b1);
        checkOutput("t1_data_p0", 32'(out_data), 32'h11);
        checkOutput("t1_ticks_p0", 32'(sample_ticks), 32'h0);
        checkOutput("t1_sos_p0", 32'(start_of_sample), 32'h1);
        checkOutput("t1_ready_p0", 32'(in_ready), 32'h0);
        nextCycle();
        checkOutput("t1_data_p1", 32'(out_data), 32'h22);
        checkOutput("t1_ticks_p1", 32'(sample_ticks), 32'h1);
        checkOutput("t1_sos_p1", 32'(start_of_sample), 32'h0);
        checkOutput("t1_ready_p1", 32'(in_ready), 32'h0);
        nextCycle();
        checkOutput("t1_data_p2", 32'(out_data), 32'h33);
        checkOutput("t1_ticks_p2", 32'(sample_ticks), 32'h2);
        checkOutput("t1_sos_p2", 32'(start_of_sample), 32'h0);
        checkOutput("t1_ready_p2", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t1_empty", 32'(out_valid), 32'h0);
        checkOutput("t1_ticks_wrap", 32'(sample_ticks), 32'h0);

        // 2: back-to-back samples with no gap
        applyStimulus(1'b1, 24'h332211, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 24'h665544, 1'b1);
        checkOutput("t2_w0", 32'(out_data), 32'h11);
        nextCycle();
        checkOutput("t2_w1", 32'(out_data), 32'h22);
        nextCycle();
        checkOutput("t2_w2", 32'(out_data), 32'h33);
        checkOutput("t2_ready_w2", 32'(in_ready), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b1);
        checkOutput("t2_w3", 32'(out_data), 32'h44);
        checkOutput("t2_valid_w3", 32'(out_valid), 32'h1);
        checkOutput("t2_sos_w3", 32'(start_of_sample), 32'h1);
        nextCycle();
        checkOutput("t2_w4", 32'(out_data), 32'h55);
        nextCycle();
        checkOutput("t2_w5", 32'(out_data), 32'h66);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t2_underflow", 32'(underflow), 32'h0);
        checkOutput("t2_empty", 32'(out_valid), 32'h0);

        // 3: parallel mode, switched under sclr
        sclr   = 1'b1;
        hd_sdn = 1'b1;
        nextCycle();
        sclr = 1'b0;
        applyStimulus(1'b1, 24'hA1A2A3, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 24'hB1B2B3, 1'b1);
        checkOutput("t3_s0", 32'(out_data), 32'hA1A2A3);
        checkOutput("t3_ready_s0", 32'(in_ready), 32'h1);
        checkOutput("t3_sos_s0", 32'(start_of_sample), 32'h1);
        nextCycle();
        applyStimulus(1'b1, 24'hC1C2C3, 1'b1);
        checkOutput("t3_s1", 32'(out_data), 32'hB1B2B3);
        checkOutput("t3_ticks_s1", 32'(sample_ticks), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 24'hD1D2D3, 1'b1);
        checkOutput("t3_s2", 32'(out_data), 32'hC1C2C3);
        checkOutput("t3_sos_s2", 32'(start_of_sample), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b1);
        checkOutput("t3_s3", 32'(out_data), 32'hD1D2D3);
        checkOutput("t3_ticks_s3", 32'(sample_ticks), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t3_empty", 32'(out_valid), 32'h0);
        checkOutput("t3_underflow", 32'(underflow), 32'h0);

        // 4: underflow is sticky until sclr
        applyStimulus(1'b0, 24'h0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t4_underflow_set", 32'(underflow), 32'h1);
        checkOutput("t4_ticks_hold", 32'(sample_ticks), 32'h0);
        nextCycle();
        checkOutput("t4_underflow_sticky", 32'(underflow), 32'h1);
        sclr   = 1'b1;
        hd_sdn = 1'b0;
        #1;
        checkOutput("t4_ready_sclr", 32'(in_ready), 32'h0);
        nextCycle();
        sclr = 1'b0;
        #1;
        checkOutput("t4_underflow_clr", 32'(underflow), 32'h0);
        checkOutput("t4_valid_clr", 32'(out_valid), 32'h0);
        checkOutput("t4_ticks_clr", 32'(sample_ticks), 32'h0);

        // 5: sclr discards a partially emitted sample
        applyStimulus(1'b1, 24'hCCBBAA, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b1);
        checkOutput("t5_p0", 32'(out_data), 32'hAA);
        nextCycle();
        checkOutput("t5_p1", 32'(out_data), 32'hBB);
        nextCycle();
        checkOutput("t5_ticks_before", 32'(sample_ticks), 32'h2);
        sclr = 1'b1;
        applyStimulus(1'b1, 24'h123456, 1'b0);
        checkOutput("t5_ready_sclr", 32'(in_ready), 32'h0);
        nextCycle();
        sclr = 1'b0;
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t5_not_accepted", 32'(out_valid), 32'h0);
        checkOutput("t5_ticks_clr", 32'(sample_ticks), 32'h0);
        applyStimulus(1'b1, 24'hFFEEDD, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b1);
        checkOutput("t5_next_p0", 32'(out_data), 32'hDD);
        checkOutput("t5_next_sos", 32'(start_of_sample), 32'h1);
        nextCycle();
        checkOutput("t5_next_p1", 32'(out_data), 32'hEE);
        nextCycle();
        checkOutput("t5_next_p2", 32'(out_data), 32'hFF);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);

        // 6: single-plane instance, then asynchronous reset mid-stream
        in_valid1 = 1'b1;
        in_data1  = 8'h7F;
        nextCycle();
        in_valid1   = 1'b1;
        in_data1    = 8'h55;
        out_enable1 = 1'b1;
        #1;
        checkOutput("t6_data", 32'(out_data1), 32'h7F);
        checkOutput("t6_sos", 32'(start_of_sample1), 32'h1);
        checkOutput("t6_ticks", 32'(sample_ticks1), 32'h0);
        checkOutput("t6_ready_refill", 32'(in_ready1), 32'h1);
        nextCycle();
        in_valid1   = 1'b0;
        out_enable1 = 1'b0;
        applyStimulus(1'b1, 24'h030201, 1'b0);
        checkOutput("t6_data_next", 32'(out_data1), 32'h55);
        checkOutput("t6_valid_next", 32'(out_valid1), 32'h1);
        checkOutput("t6_underflow", 32'(underflow1), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 24'h0, 1'b0);
        checkOutput("t6_big_loaded", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid1", 32'(out_valid1), 32'h0);
        checkOutput("t6_async_valid", 32'(out_valid), 32'h0);
        checkOutput("t6_async_data", 32'(out_data), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
